// File: rtl/ioctl_rom_loader.sv
// ioctl download stream to toggle-handshake RAM writer: packs PACK words per beat,
// buffers beats in a small FIFO and issues them with a req/ack toggle pair.
module ioctl_rom_loader #(
  parameter int DATA_W = 16,
  parameter int PACK   = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 25,
  parameter int SWAP   = 1
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       ioctl_download,
  input  logic                       ioctl_wr,
  input  logic [ADDR_W-1:0]          ioctl_addr,
  input  logic [DATA_W-1:0]          ioctl_data,
  output logic                       ioctl_wait,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W*PACK-1:0]     mem_din,
  output logic [DATA_W*PACK/8-1:0]   mem_be,
  output logic                       mem_req,
  input  logic                       mem_ack,
  output logic [ADDR_W-1:0]          rom_size,
  output logic                       busy
);

  localparam int BYTES   = DATA_W / 8;
  localparam int BEAT_W  = DATA_W * PACK;
  localparam int BE_W    = BYTES * PACK;
  localparam int LANE_SH = $clog2(BYTES);
  localparam int LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BE_W - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 dl_q;
  logic [ADDR_W-1:0]    pk_addr_q, pk_addr_d;
  logic [BEAT_W-1:0]    pk_data_q, pk_data_d;
  logic [BE_W-1:0]      pk_be_q, pk_be_d;

  logic [ADDR_W-1:0]    f_addr_q [DEPTH];
  logic [BEAT_W-1:0]    f_data_q [DEPTH];
  logic [BE_W-1:0]      f_be_q   [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 wait_q, wait_d;
  logic                 req_q;
  logic [ADDR_W-1:0]    maddr_q;
  logic [BEAT_W-1:0]    mdin_q;
  logic [BE_W-1:0]      mbe_q;
  logic [ADDR_W-1:0]    rom_size_q;

  logic                 dl_rise, dl_fall, wr_ok, wr_close;
  logic [DATA_W-1:0]    word;
  logic [ADDR_W-1:0]    w_beat, w_end;
  logic [LANE_W-1:0]    w_lane;
  logic                 push, push_ok, issue, avail;
  logic [ADDR_W-1:0]    push_addr;
  logic [BEAT_W-1:0]    push_data;
  logic [BE_W-1:0]      push_be;

  // Pack path. At most one beat is pushed per cycle; when a gap push and a
  // top-lane write coincide, the new beat stays packed with its top lane set
  // and is flushed on the following cycle ahead of any new word.
  always_comb begin
    word = ioctl_data;
    if (SWAP != 0) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        word[i*8 +: 8] = ioctl_data[(BYTES-1-i)*8 +: 8];
      end
    end
    wr_ok   = ioctl_wr & ioctl_download;
    dl_rise = ioctl_download & ~dl_q;
    dl_fall = ~ioctl_download & dl_q;
    w_beat  = ioctl_addr & ~BEAT_MASK;
    w_end   = ioctl_addr + ADDR_W'(BYTES);
    w_lane  = (PACK == 1) ? '0 : LANE_W'(ioctl_addr >> LANE_SH);

    pk_addr_d = pk_addr_q;
    pk_data_d = pk_data_q;
    pk_be_d   = pk_be_q;
    push      = 1'b0;
    push_addr = pk_addr_q;
    push_data = pk_data_q;
    push_be   = pk_be_q;
    wr_close  = wr_ok && ((w_lane == LANE_W'(PACK-1)) ||
                          ((pk_be_q != '0) && (w_beat != pk_addr_q)));

    if (dl_rise) begin
      pk_data_d = '0;
      pk_be_d   = '0;
    end else if (pk_be_q[BE_W-1] ||
                 (wr_ok && (pk_be_q != '0) && (w_beat != pk_addr_q)) ||
                 (dl_fall && (pk_be_q != '0))) begin
      push      = 1'b1;
      pk_data_d = '0;
      pk_be_d   = '0;
    end

    if (wr_ok) begin
      if (pk_be_d == '0) begin
        pk_addr_d = w_beat;
      end
      for (int unsigned i = 0; i < PACK; i++) begin
        if (w_lane == LANE_W'(i)) begin
          pk_data_d[i*DATA_W +: DATA_W] = word;
          pk_be_d[i*BYTES +: BYTES]     = '1;
        end
      end
      if ((w_lane == LANE_W'(PACK-1)) && !push) begin
        push      = 1'b1;
        push_addr = pk_addr_d;
        push_data = pk_data_d;
        push_be   = pk_be_d;
        pk_data_d = '0;
        pk_be_d   = '0;
      end
    end
  end

  assign avail   = (cnt_q != '0) && !dl_rise;
  assign push_ok = push && ((cnt_q != CNT_W'(DEPTH)) || issue);
  assign wait_d  = (cnt_q >= CNT_W'(DEPTH-1)) ||
                   (wr_close && (cnt_q == CNT_W'(DEPTH-2)));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q       <= 1'b0;
      pk_addr_q  <= '0;
      pk_data_q  <= '0;
      pk_be_q    <= '0;
      rom_size_q <= '0;
      wait_q     <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      pk_addr_q <= pk_addr_d;
      pk_data_q <= pk_data_d;
      pk_be_q   <= pk_be_d;
      wait_q    <= wait_d;
      if (dl_rise) begin
        rom_size_q <= wr_ok ? w_end : '0;
      end else if (wr_ok && (w_end > rom_size_q)) begin
        rom_size_q <= w_end;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || dl_rise) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(issue);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok && !dl_rise) begin
      f_addr_q[wr_ptr_q] <= push_addr;
      f_data_q[wr_ptr_q] <= push_data;
      f_be_q[wr_ptr_q]   <= push_be;
    end
  end

  // Issue FSM
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      maddr_q <= '0;
      mdin_q  <= '0;
      mbe_q   <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        req_q   <= ~req_q;
        maddr_q <= f_addr_q[rd_ptr_q];
        mdin_q  <= f_data_q[rd_ptr_q];
        mbe_q   <= f_be_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (avail && (req_q == mem_ack)) state_d = S_WAIT;
      S_WAIT: if (req_q == mem_ack)            state_d = avail ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      S_IDLE:  issue = avail && (req_q == mem_ack);
      S_WAIT:  issue = avail && (req_q == mem_ack);
      default: issue = 1'b0;
    endcase
  end

  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = maddr_q;
  assign mem_din    = mdin_q;
  assign mem_be     = mbe_q;
  assign rom_size   = rom_size_q;
  assign busy       = (pk_be_q != '0) || (cnt_q != '0) || (req_q != mem_ack);

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Scoreboard bench for ioctl_rom_loader: expected beats are queued at stimulus time
// and a monitor pops/compares on every mem_req toggle.
module tb_ioctl_rom_loader;
  localparam int DATA_W = 16;
  localparam int PACK   = 4;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, ioctl_download, ioctl_wr, ioctl_wait;
  logic [ADDR_W-1:0] ioctl_addr, mem_addr, rom_size;
  logic [DATA_W-1:0] ioctl_data;
  logic [63:0]       mem_din;
  logic [7:0]        mem_be;
  logic              mem_req, mem_ack, busy;

  ioctl_rom_loader #(.DATA_W(DATA_W), .PACK(PACK), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SWAP(1)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_req(mem_req),
    .mem_ack(mem_ack), .rom_size(rom_size), .busy(busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [63:0]       d;
    logic [7:0]        be;
  } beat_t;

  beat_t expq[$];
  int    tog_t[$];
  int    checks = 0, errors = 0, cyc = 0, tog_n = 0;
  bit    freeze = 1'b0, mon_en = 1'b0;
  logic  prev_req;

  // Memory controller: acks the toggle one cycle after seeing it, unless frozen
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) mem_ack <= 1'b0;
    else if (!freeze) mem_ack <= mem_req;
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_req = mem_req;
    end else if (mem_req !== prev_req) begin
      beat_t e;
      prev_req = mem_req;
      tog_n++;
      tog_t.push_back(cyc);
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got addr=%h din=%h be=%h", mem_addr, mem_din, mem_be);
      end else begin
        e = expq.pop_front();
        if ({mem_addr, mem_din, mem_be} !== e) begin
          errors++;
          $display("FAIL beat got addr=%h din=%h be=%h want addr=%h din=%h be=%h",
                   mem_addr, mem_din, mem_be, e.a, e.d, e.be);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    int k = 0;
    while (ioctl_wait && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout got ioctl_wait=1 want 0 within 300 cycles");
    end
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
    @(negedge clk);
  endtask

  // Sequential 16-bit words from addr base; every 4th word completes a beat
  task automatic stream(input int n, input int base, input logic [15:0] dat0);
    beat_t cur = '0;
    for (int k = 0; k < n; k++) begin
      logic [15:0] d = dat0 + 16'(k);
      int lane = ((base + 2*k) / 2) % PACK;
      cur.a = ADDR_W'((base + 2*k) & ~7);
      cur.d[lane*16 +: 16] = {d[7:0], d[15:8]};
      cur.be[lane*2 +: 2]  = 2'b11;
      if (lane == PACK-1) begin
        expq.push_back(cur);
        cur = '0;
      end
      wr(ADDR_W'(base + 2*k), d);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain_busy", 64'(busy), 64'd0);
    check("queue_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int t0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    tick(3);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_din", mem_din, 64'd0);
    check("rst_be", 64'(mem_be), 64'd0);
    check("rst_rom_size", 64'(rom_size), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick(1);
    mon_en = 1'b1;

    // Full beat with byte swap
    ioctl_download = 1'b1; tick(1);
    expq.push_back('{a: '0, d: 64'hF0DEBC9A78563412, be: 8'hFF});
    wr(25'h0, 16'h1234); wr(25'h2, 16'h5678); wr(25'h4, 16'h9ABC); wr(25'h6, 16'hDEF0);
    ioctl_download = 1'b0; tick(1);
    drain();
    check("rom_size_full", 64'(rom_size), 64'd8);

    // Partial beat flushed by download falling edge
    ioctl_download = 1'b1; tick(1);
    check("rom_size_cleared", 64'(rom_size), 64'd0);
    expq.push_back('{a: '0, d: 64'h000003CC02BB01AA, be: 8'h3F});
    wr(25'h0, 16'hAA01); wr(25'h2, 16'hBB02); wr(25'h4, 16'hCC03);
    ioctl_download = 1'b0; tick(1);
    drain();
    check("rom_size_partial", 64'(rom_size), 64'd6);

    // Address gap closes the open beat
    ioctl_download = 1'b1; tick(1);
    expq.push_back('{a: '0,     d: 64'h000000000000B2A1, be: 8'h03});
    expq.push_back('{a: 25'h10, d: 64'h000000000000D4C3, be: 8'h03});
    wr(25'h0, 16'hA1B2); wr(25'h10, 16'hC3D4);
    ioctl_download = 1'b0; tick(1);
    drain();
    check("rom_size_gap", 64'(rom_size), 64'h12);

    // Writes outside a download are ignored
    wr(25'h100, 16'hFFFF); tick(4);
    check("ignored_rom_size", 64'(rom_size), 64'h12);
    check("ignored_busy", 64'(busy), 64'd0);

    // Backpressure: frozen ack, 20 words
    t0 = tog_n;
    ioctl_download = 1'b1; freeze = 1'b1; tick(1);
    stream(16, 0, 16'h1000);
    check("bp_wait_high", 64'(ioctl_wait), 64'd1);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_toggles_frozen", 64'(tog_n - t0), 64'd1);
    freeze = 1'b0;
    stream(4, 32, 16'h1010);
    ioctl_download = 1'b0; tick(1);
    drain();
    check("bp_toggles", 64'(tog_n - t0), 64'd5);
    check("rom_size_bp", 64'(rom_size), 64'h28);

    // Back-to-back issue from a full FIFO
    t0 = tog_n;
    tog_t.delete();
    ioctl_download = 1'b1; freeze = 1'b1; tick(1);
    stream(16, 0, 16'h2000);
    freeze = 1'b0;
    stream(16, 32, 16'h2010);
    ioctl_download = 1'b0; tick(1);
    drain();
    check("b2b_toggles", 64'(tog_n - t0), 64'd8);
    if (tog_t.size() >= 4) begin
      check("b2b_gap1", 64'(tog_t[2] - tog_t[1]), 64'd2);
      check("b2b_gap2", 64'(tog_t[3] - tog_t[2]), 64'd2);
    end else begin
      check("b2b_toggle_count", 64'(tog_t.size()), 64'd4);
    end

    // Reset with a beat in flight and the FIFO backed up
    ioctl_download = 1'b1; freeze = 1'b1; tick(1);
    stream(16, 0, 16'h3000);
    check("rst_mid_wait_before", 64'(ioctl_wait), 64'd1);
    mon_en = 1'b0;
    expq.delete();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_wait", 64'(ioctl_wait), 64'd0);
    check("rst_mid_req", 64'(mem_req), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_rom_size", 64'(rom_size), 64'd0);
    freeze = 1'b0;
    ioctl_download = 1'b0;
    tick(2);
    mon_en = 1'b1;
    tick(10);
    check("final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
